// File: rtl/parallel_to_serial_pkg.sv
// parallel_to_serial_pkg: serial link word format and transmitter state encoding
package parallel_to_serial_pkg;
  localparam int LINK_WIDTH = 8;
  localparam logic [7:0] LINK_COMMA = 8'hBC;
  localparam int LINK_N_SYNC = 2;
  typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/p2s_hold_buf.sv
// p2s_hold_buf: one-entry holding register for a word accepted mid-slot
module p2s_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_wr,
  input  logic             i_rd,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic [WIDTH-1:0] o_q
);
  logic             r_full;
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge CLK) begin
    if (RESET) r_full <= 1'b0;
    else r_full <= i_wr | (r_full & ~i_rd);
    if (i_wr) r_q <= i_data;
  end
  assign o_full = r_full;
  assign o_q = r_q;
endmodule

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: MSB-first serialiser with comma alignment preamble and comma idle fill
module parallel_to_serial
  import parallel_to_serial_pkg::*;
#(
  parameter int               WIDTH  = LINK_WIDTH,
  parameter logic [WIDTH-1:0] COMMA  = WIDTH'(LINK_COMMA),
  parameter int               N_SYNC = LINK_N_SYNC
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic             DATA_OUT,
  output logic             BYTE_START,
  output logic             SYNCED
);
  localparam int BW = $clog2(WIDTH);
  localparam int SW = $clog2(N_SYNC + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [SW-1:0] LAST_SYNC = SW'(N_SYNC - 1);
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sr, w_word, w_q;
  logic [BW-1:0]    r_bit_cnt;
  logic [SW-1:0]    r_sync_cnt;
  logic             w_boundary, w_accept, w_bypass, w_full;
  assign w_boundary = r_bit_cnt == LAST_BIT;
  assign w_accept = VALID_IN && READY_OUT;
  assign w_bypass = w_accept && w_boundary;
  assign SYNCED = r_state == ST_RUN;
  assign READY_OUT = SYNCED && !w_full;
  assign DATA_OUT = r_sr[WIDTH-1];
  assign BYTE_START = r_bit_cnt == '0;
  p2s_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_wr   (w_accept && !w_bypass),
    .i_rd   (w_boundary && w_full),
    .i_data (DATA_IN),
    .o_full (w_full),
    .o_q    (w_q)
  );
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_SYNC;
    else r_state <= w_state_nxt;
  end
  // hold always wins over a bypass so words leave in acceptance order
  always_comb begin
    w_state_nxt = (r_state == ST_SYNC && w_boundary && r_sync_cnt == LAST_SYNC) ? ST_RUN : r_state;
    w_word = r_state != ST_RUN ? COMMA : w_full ? w_q : w_bypass ? DATA_IN : COMMA;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sr <= COMMA;
      r_bit_cnt <= '0;
      r_sync_cnt <= '0;
    end else begin
      r_sr <= w_boundary ? w_word : {r_sr[WIDTH-2:0], 1'b0};
      r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + 1'b1;
      if (r_state == ST_SYNC && w_boundary) r_sync_cnt <= r_sync_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: slot-level reference model feeding a word scoreboard for the serialiser
module tb_parallel_to_serial;
  localparam int W = 8;
  localparam logic [W-1:0] C = 8'hBC;
  localparam int NS = 2;
  logic CLK = 0, RESET = 1, VALID_IN = 0;
  logic [W-1:0] DATA_IN = '0;
  logic DATA_OUT, BYTE_START, READY_OUT, SYNCED;
  parallel_to_serial dut (
    .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .VALID_IN(VALID_IN),
    .READY_OUT(READY_OUT), .DATA_OUT(DATA_OUT), .BYTE_START(BYTE_START), .SYNCED(SYNCED)
  );
  always #5 CLK = ~CLK;
  int cyc = 0, vectors = 0, miscompares = 0;
  bit started = 0, last_acc = 0;
  logic [W-1:0] pending[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] bits = '0;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d t=%0t: got %h expected %h", name, cyc, $time, act, exp);
    end
  endtask
  // line model: slot k carries whatever word is oldest-unsent at the edge that starts it
  initial forever begin
    @(posedge CLK);
    if (RESET) begin
      started = 1;
      cyc = 0;
      last_acc = 0;
      pending.delete();
      exp_q.delete();
      exp_q.push_back(C);
    end else if (started) begin
      last_acc = VALID_IN && cyc >= NS * W && pending.size() == 0;
      if (last_acc) pending.push_back(DATA_IN);
      if (cyc % W == W - 1) begin
        if (pending.size() > 0) exp_q.push_back(pending.pop_front());
        else exp_q.push_back(C);
      end
      cyc++;
    end
  end
  initial forever begin
    @(negedge CLK);
    if (started) begin
      chk("byte_start", W'(BYTE_START), W'(cyc % W == 0));
      chk("synced", W'(SYNCED), W'(cyc >= NS * W));
      chk("ready", W'(READY_OUT), W'(cyc >= NS * W && pending.size() == 0));
      bits[W-1-(cyc%W)] = DATA_OUT;
      if (cyc % W == W - 1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL word cyc=%0d: got %h expected none queued", cyc, bits);
        end else chk("word", bits, exp_q.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [W-1:0] d);
    int n = 0;
    VALID_IN = 1;
    DATA_IN = d;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    VALID_IN = 0;
    if (!last_acc) chk("send_timeout", '0, 8'h01);
  endtask
  initial begin
    int n;
    logic [W-1:0] burst[5] = '{8'hF7, 8'hBC, 8'hAA, 8'h0C, 8'h55};
    tick();
    tick();
    RESET = 0;
    while (cyc < 16) tick();
    send(8'hAA);
    repeat (30) tick();
    foreach (burst[i]) send(burst[i]);
    n = 0;
    while ((cyc % W != W - 1 || pending.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    VALID_IN = 1;
    DATA_IN = 8'h0C;
    tick();
    VALID_IN = 0;
    chk("bypass_accept", W'(last_acc), 8'h01);
    chk("bypass_msb", W'({DATA_OUT, BYTE_START}), 8'h01);
    repeat (20) tick();
    send(8'h55);
    send(8'hAA);
    n = 0;
    while (cyc % W != 3 && n < 20) begin
      tick();
      n++;
    end
    RESET = 1;
    tick();
    RESET = 0;
    chk("rst_state", W'({DATA_OUT, SYNCED, READY_OUT, BYTE_START}), 8'h09);
    repeat (200) begin
      repeat ($urandom_range(0, 12)) tick();
      send(W'($urandom));
    end
    n = 0;
    while (pending.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    repeat (3 * W) tick();
    chk("drain", W'(pending.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
